// File: rtl/router_pkg.sv
// Shared router definitions: packet header layout, channel count and the
// transmit FSM state encoding.
package router_pkg;

    localparam int NUM_CH       = 3;
    localparam int HDR_LEN_MSB  = 5;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_DEST_MSB = 1;
    localparam int HDR_DEST_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        PAR  = 2'd3
    } tx_state_e;

    function automatic logic [7:0] make_hdr(input logic [3:0] len, input logic [1:0] dest);
        logic [7:0] h;
        h = '0;
        h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
        h[HDR_DEST_MSB:HDR_DEST_LSB] = dest;
        return h;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO for packet payload. Exposes the head entry and the one behind it
// so the framer can preload the next byte at the same edge it pops.
module tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               head,
    output logic [7:0]               head_nxt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [CW-1:0] cnt_q;
    logic          wr_ok, rd_ok;

    // Full is judged before any same-edge pop, so a write to a full FIFO is dropped.
    assign full     = (cnt_q == CW'(DEPTH));
    assign count    = cnt_q;
    assign wr_ok    = push & ~full;
    assign rd_ok    = pop & (cnt_q != '0);
    assign rd_nxt   = rd_ptr_q + AW'(1);
    assign head     = mem_q[rd_ptr_q];
    assign head_nxt = mem_q[rd_nxt];

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_ok) rd_ptr_q <= rd_nxt;
            case ({wr_ok, rd_ok})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/packet_tx.sv
// Packet transmitter: frames header, FIFO payload and XOR parity onto a
// stallable byte stream.
module packet_tx
    import router_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   fifo_full,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    input  logic                   send,
    input  logic [1:0]             send_dest,
    input  logic [3:0]             send_len,
    input  logic                   par_inv,
    output logic                   cmd_ack,
    output logic                   cmd_err,
    input  logic                   stall,
    output logic                   pkt_v,
    output logic [7:0]             dout,
    output logic                   tx_busy,
    output logic                   done
);

    tx_state_e  state_q;
    logic [3:0] len_q, idx_q;
    logic       inv_q;
    logic [7:0] par_q, dout_q;
    logic       ack_q, err_q, busy_q, done_q;

    logic       byte_valid, cmd_ok, accept, pop, last;
    logic [7:0] hdr_d, par_d, head, head_nxt;

    tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .full      (fifo_full),
        .count     (fifo_cnt),
        .head      (head),
        .head_nxt  (head_nxt)
    );

    assign byte_valid = (state_q != IDLE);
    assign pkt_v      = byte_valid & ~stall;
    assign cmd_ok     = (state_q == IDLE) && (int'(send_dest) < NUM_CH) &&
                        (send_len != 4'd0) && (int'(fifo_cnt) >= int'(send_len));
    assign accept     = send & cmd_ok;
    assign pop        = pkt_v && (state_q == PAY);
    assign last       = (idx_q == len_q - 4'd1);
    assign hdr_d      = make_hdr(send_len, send_dest);
    // dout_q holds the byte being transferred, so folding it in covers header and payload.
    assign par_d      = par_q ^ dout_q;

    assign dout    = dout_q;
    assign cmd_ack = ack_q;
    assign cmd_err = err_q;
    assign tx_busy = busy_q;
    assign done    = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            inv_q   <= 1'b0;
            par_q   <= '0;
            dout_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ack_q  <= accept;
            err_q  <= send & ~accept;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    state_q <= HDR;
                    len_q   <= send_len;
                    inv_q   <= par_inv;
                    idx_q   <= '0;
                    dout_q  <= hdr_d;
                    par_q   <= '0;
                    busy_q  <= 1'b1;
                end
                HDR: if (pkt_v) begin
                    state_q <= PAY;
                    par_q   <= par_d;
                    dout_q  <= head;
                end
                PAY: if (pkt_v) begin
                    par_q <= par_d;
                    idx_q <= idx_q + 4'd1;
                    if (last) begin
                        state_q <= PAR;
                        dout_q  <= par_d ^ {8{inv_q}};
                    end else begin
                        dout_q  <= head_nxt;
                    end
                end
                PAR: if (pkt_v) begin
                    state_q <= IDLE;
                    dout_q  <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_tx.sv
// Directed bench for packet_tx: framing, stall, rejects, full FIFO,
// parity inversion and mid-packet reset.
module tb_packet_tx;

    logic       clk = 1'b0;
    logic       rst_n, wr_en, send, par_inv, stall;
    logic [7:0] wr_data;
    logic [1:0] send_dest;
    logic [3:0] send_len;
    logic       fifo_full, cmd_ack, cmd_err, pkt_v, tx_busy, done;
    logic [4:0] fifo_cnt;
    logic [7:0] dout;

    int checks = 0;
    int errors = 0;

    packet_tx #(.DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .fifo_full(fifo_full), .fifo_cnt(fifo_cnt), .send(send),
        .send_dest(send_dest), .send_len(send_len), .par_inv(par_inv),
        .cmd_ack(cmd_ack), .cmd_err(cmd_err), .stall(stall), .pkt_v(pkt_v),
        .dout(dout), .tx_busy(tx_busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1; wr_data = b;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] d, input logic [3:0] l, input logic inv);
        send = 1'b1; send_dest = d; send_len = l; par_inv = inv;
        tick();
        send = 1'b0; par_inv = 1'b0;
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        chk({tag, "_v"}, pkt_v, 1);
        chk(tag, dout, exp);
        tick();
    endtask

    task automatic expect_done(input string tag);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, tx_busy, 0);
        chk({tag, "_v"}, pkt_v, 0);
        chk({tag, "_dout"}, dout, 8'h00);
        tick();
        chk({tag, "_done1"}, done, 0);
    endtask

    task automatic expect_reject(input string tag);
        chk({tag, "_err"}, cmd_err, 1);
        chk({tag, "_ack"}, cmd_ack, 0);
        chk({tag, "_v"}, pkt_v, 0);
        chk({tag, "_cnt"}, fifo_cnt, 3);
        tick();
        chk({tag, "_err1"}, cmd_err, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; send = 1'b0;
        send_dest = '0; send_len = '0; par_inv = 1'b0; stall = 1'b0;
        #12;
        chk("rst_v", pkt_v, 0);
        chk("rst_cnt", fifo_cnt, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_dout", dout, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_ack", cmd_ack, 0);
        rst_n = 1'b1;
        tick();

        // Basic packet: dest=1 len=3
        push(8'h11); push(8'h22); push(8'h33);
        chk("b_cnt", fifo_cnt, 3);
        send_cmd(2'd1, 4'd3, 1'b0);
        chk("b_ack", cmd_ack, 1);
        chk("b_busy", tx_busy, 1);
        expect_byte("b_hdr", 8'h0D);
        chk("b_cnt_hdr", fifo_cnt, 3);
        expect_byte("b_p0", 8'h11);
        chk("b_cnt_p0", fifo_cnt, 2);
        expect_byte("b_p1", 8'h22);
        expect_byte("b_p2", 8'h33);
        expect_byte("b_par", 8'h0D);
        expect_done("b");
        chk("b_cnt_end", fifo_cnt, 0);

        // Same packet, 3-cycle stall while 0x22 is presented
        push(8'h11); push(8'h22); push(8'h33);
        send_cmd(2'd1, 4'd3, 1'b0);
        expect_byte("s_hdr", 8'h0D);
        expect_byte("s_p0", 8'h11);
        stall = 1'b1;
        repeat (3) begin
            #1;
            chk("s_stall_v", pkt_v, 0);
            chk("s_stall_dout", dout, 8'h22);
            chk("s_stall_busy", tx_busy, 1);
            tick();
        end
        stall = 1'b0;
        #1;
        expect_byte("s_p1", 8'h22);
        expect_byte("s_p2", 8'h33);
        expect_byte("s_par", 8'h0D);
        expect_done("s");
        chk("s_cnt_end", fifo_cnt, 0);

        // Rejects with 3 bytes queued, then a valid send with a busy-time reject
        push(8'hAA); push(8'hBB); push(8'hCC);
        send_cmd(2'd0, 4'd4, 1'b0);
        expect_reject("r_len4");
        send_cmd(2'd3, 4'd1, 1'b0);
        expect_reject("r_dest3");
        send_cmd(2'd0, 4'd0, 1'b0);
        expect_reject("r_len0");
        send_cmd(2'd2, 4'd3, 1'b0);
        chk("r_ack", cmd_ack, 1);
        send = 1'b1; send_dest = 2'd0; send_len = 4'd1;
        expect_byte("r_hdr", 8'h0E);
        send = 1'b0;
        chk("r_busy_err", cmd_err, 1);
        expect_byte("r_p0", 8'hAA);
        expect_byte("r_p1", 8'hBB);
        expect_byte("r_p2", 8'hCC);
        expect_byte("r_par", 8'hD3);
        expect_done("r");

        // Full FIFO: 17 writes, 17th dropped
        for (int i = 1; i <= 17; i++) push(8'(i));
        chk("f_full", fifo_full, 1);
        chk("f_cnt", fifo_cnt, 16);
        send_cmd(2'd0, 4'd15, 1'b0);
        expect_byte("f_hdr", 8'h3C);
        for (int i = 1; i <= 15; i++) expect_byte("f_pay", 8'(i));
        expect_byte("f_par", 8'h3C);
        expect_done("f");
        chk("f_cnt_end", fifo_cnt, 1);
        chk("f_full_end", fifo_full, 0);
        send_cmd(2'd0, 4'd1, 1'b0);
        expect_byte("f2_hdr", 8'h04);
        wr_en = 1'b1; wr_data = 8'h55;
        expect_byte("f2_p0", 8'h10);
        wr_en = 1'b0;
        chk("f2_cnt_wrpop", fifo_cnt, 1);
        expect_byte("f2_par", 8'h14);
        expect_done("f2");
        send_cmd(2'd2, 4'd1, 1'b0);
        expect_byte("f3_hdr", 8'h06);
        expect_byte("f3_p0", 8'h55);
        expect_byte("f3_par", 8'h53);
        expect_done("f3");
        chk("f3_cnt", fifo_cnt, 0);

        // Inverted parity
        push(8'h11); push(8'h22); push(8'h33);
        send_cmd(2'd1, 4'd3, 1'b1);
        expect_byte("i_hdr", 8'h0D);
        expect_byte("i_p0", 8'h11);
        expect_byte("i_p1", 8'h22);
        expect_byte("i_p2", 8'h33);
        expect_byte("i_par", 8'hF2);
        expect_done("i");

        // Reset during the second payload byte
        push(8'h11); push(8'h22); push(8'h33);
        send_cmd(2'd1, 4'd3, 1'b0);
        expect_byte("x_hdr", 8'h0D);
        expect_byte("x_p0", 8'h11);
        chk("x_p1_pres", dout, 8'h22);
        #2;
        rst_n = 1'b0;
        #1;
        chk("x_rst_v", pkt_v, 0);
        chk("x_rst_cnt", fifo_cnt, 0);
        chk("x_rst_busy", tx_busy, 0);
        chk("x_rst_dout", dout, 0);
        tick();
        rst_n = 1'b1;
        tick();
        send_cmd(2'd1, 4'd1, 1'b0);
        chk("x_post_err", cmd_err, 1);
        chk("x_post_v", pkt_v, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
